// File: rtl/ibf_pkg.sv
// Shared definitions for the IBF insert/delete engine: FSM encoding, op codes,
// and the helper that slices a CRC code into cell indices.
`ifndef KeyField
`define KeyField 32
`endif
`ifndef CRCLength
`define CRCLength 32
`endif

package ibf_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_KICK,
        ST_WAIT,
        ST_UPD,
        ST_FIN
    } ibf_state_e;

    localparam logic OP_INS = 1'b0;
    localparam logic OP_DEL = 1'b1;

    // Index i occupies code[i*aw +: aw]; callers truncate to their address width.
    function automatic logic [31:0] cell_index(input logic [63:0] code, input int i, input int aw);
        logic [63:0] mask;
        mask = (64'd1 << aw) - 64'd1;
        return 32'((code >> (i * aw)) & mask);
    endfunction

endpackage

// File: rtl/ibf_cell_ram.sv
// IBF cell storage: one synchronous write port, a combinational read port for
// the read-modify-write path, and a registered read-before-write sweep port.
module ibf_cell_ram #(
    parameter int ADDR_W = 8,
    parameter int CELL_W = 72
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [CELL_W-1:0] wdata,
    input  logic [ADDR_W-1:0] rmw_addr,
    output logic [CELL_W-1:0] rmw_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CELL_W-1:0] rd_data
);

    logic [CELL_W-1:0] mem_q [1<<ADDR_W];
    logic [CELL_W-1:0] rd_d, rd_q;

    always_comb begin
        rd_d     = mem_q[rd_addr];
        rmw_data = mem_q[rmw_addr];
    end

    // No reset on the array itself; the FSM wipes it cell by cell.
    always_ff @(posedge CLK) begin
        if (we) mem_q[waddr] <= wdata;
    end

    always_ff @(posedge CLK) begin
        if (reset) rd_q <= '0;
        else       rd_q <= rd_d;
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/ibf_inserter.sv
// IBF insert/delete engine: hands a key to the CRC generator, then applies one
// read-modify-write per CRC-derived cell index. Reset forces a full array clear.
module ibf_inserter import ibf_pkg::*; #(
    parameter int KEY_W  = `KeyField,
    parameter int CRC_W  = `CRCLength,
    parameter int ADDR_W = 8,
    parameter int K      = 3,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic [KEY_W-1:0]  key,
    output logic              busy,
    output logic              done,
    output logic              crc_start,
    output logic [KEY_W-1:0]  crc_key,
    input  logic              crc_done,
    input  logic [CRC_W-1:0]  crc_code,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CNT_W-1:0]  rd_count,
    output logic [KEY_W-1:0]  rd_keysum,
    output logic [CRC_W-1:0]  rd_hashsum
);

    localparam int CELL_W = CNT_W + KEY_W + CRC_W;
    localparam int IDX_W  = (K > 1) ? $clog2(K) : 1;

    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic [KEY_W-1:0] key_sum;
        logic [CRC_W-1:0] hash_sum;
    } cell_t;

    ibf_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic              op_q, op_d;
    logic [CRC_W-1:0]  code_q, code_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic              we;
    logic [ADDR_W-1:0] waddr, upd_idx;
    cell_t             wdata, rmw_cell, rd_cell;

    ibf_cell_ram #(.ADDR_W(ADDR_W), .CELL_W(CELL_W)) u_ram (
        .CLK      (CLK),
        .reset    (reset),
        .we       (we & ~reset),
        .waddr    (waddr),
        .wdata    (wdata),
        .rmw_addr (upd_idx),
        .rmw_data (rmw_cell),
        .rd_addr  (rd_addr),
        .rd_data  (rd_cell)
    );

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        key_d     = key_q;
        op_d      = op_q;
        code_d    = code_q;
        idx_d     = idx_q;
        we        = 1'b0;
        waddr     = clr_ptr_q;
        wdata     = '0;
        upd_idx   = ADDR_W'(cell_index(64'(code_q), int'(idx_q), ADDR_W));
        case (state_q)
            ST_CLEAR: begin
                we        = 1'b1;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == {ADDR_W{1'b1}}) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (start) begin
                    key_d   = key;
                    op_d    = op;
                    state_d = ST_KICK;
                end
            end
            ST_KICK: state_d = ST_WAIT;
            ST_WAIT: begin
                // crc_code may float outside crc_done cycles, so only sample here.
                if (crc_done) begin
                    code_d  = crc_code;
                    idx_d   = '0;
                    state_d = ST_UPD;
                end
            end
            ST_UPD: begin
                we             = 1'b1;
                waddr          = upd_idx;
                wdata          = rmw_cell;
                wdata.count    = (op_q == OP_DEL) ? rmw_cell.count - CNT_W'(1)
                                                  : rmw_cell.count + CNT_W'(1);
                wdata.key_sum  = rmw_cell.key_sum ^ key_q;
                wdata.hash_sum = rmw_cell.hash_sum ^ code_q;
                idx_d          = idx_q + 1'b1;
                if (idx_q == IDX_W'(K - 1)) state_d = ST_FIN;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            key_q     <= '0;
            op_q      <= OP_INS;
            code_q    <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            key_q     <= key_d;
            op_q      <= op_d;
            code_q    <= code_d;
            idx_q     <= idx_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FIN);
    assign crc_start  = (state_q == ST_KICK);
    assign crc_key    = key_q;
    assign rd_count   = rd_cell.count;
    assign rd_keysum  = rd_cell.key_sum;
    assign rd_hashsum = rd_cell.hash_sum;

endmodule

// File: tb/tb_ibf_inserter.sv
// Directed + randomized bench for ibf_inserter with a fixed-latency CRC stub
// and a per-cell array model of the filter contents.
module tb_ibf_inserter;

    localparam int L = 33;
    localparam int LAT = 1 + L + 3 + 1;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] key = '0;
    logic        busy, done, crc_start, crc_done;
    logic [31:0] crc_key;
    wire  [31:0] crc_code;
    logic [7:0]  rd_addr = '0;
    logic [7:0]  rd_count;
    logic [31:0] rd_keysum, rd_hashsum;

    int tests = 0;
    int fails = 0;
    int stub_cnt = 0;
    int cs_cnt = 0;
    int done_cnt = 0;
    logic [31:0] stub_code = '0;

    logic [7:0]  m_cnt [256];
    logic [31:0] m_ks  [256];
    logic [31:0] m_hs  [256];

    ibf_inserter dut (
        .CLK(CLK), .reset(reset), .start(start), .op(op), .key(key),
        .busy(busy), .done(done), .crc_start(crc_start), .crc_key(crc_key),
        .crc_done(crc_done), .crc_code(crc_code), .rd_addr(rd_addr),
        .rd_count(rd_count), .rd_keysum(rd_keysum), .rd_hashsum(rd_hashsum)
    );

    always #5 CLK = ~CLK;

    // CRC stub: done is first seen L cycles after the crc_start cycle.
    assign crc_done = (stub_cnt == 1);
    assign crc_code = crc_done ? stub_code : 'z;
    always @(posedge CLK) begin
        if (reset)            stub_cnt <= 0;
        else if (crc_start)   stub_cnt <= L;
        else if (stub_cnt > 0) stub_cnt <= stub_cnt - 1;
        if (crc_start) cs_cnt <= cs_cnt + 1;
        if (done)      done_cnt <= done_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int a = 0; a < 256; a++) begin
            m_cnt[a] = 8'd0;
            m_ks[a]  = 32'd0;
            m_hs[a]  = 32'd0;
        end
    endtask

    task automatic model_apply(input logic o, input logic [31:0] k, input logic [31:0] c);
        for (int i = 0; i < 3; i++) begin
            int a;
            a = int'((c >> (8 * i)) & 32'hFF);
            m_cnt[a] = o ? m_cnt[a] - 8'd1 : m_cnt[a] + 8'd1;
            m_ks[a]  = m_ks[a] ^ k;
            m_hs[a]  = m_hs[a] ^ c;
        end
    endtask

    task automatic check_cell(input int a);
        rd_addr = 8'(a);
        @(posedge CLK); #1;
        chk($sformatf("cell%0d_count", a),   64'(rd_count),   64'(m_cnt[a]));
        chk($sformatf("cell%0d_keysum", a),  64'(rd_keysum),  64'(m_ks[a]));
        chk($sformatf("cell%0d_hashsum", a), 64'(rd_hashsum), 64'(m_hs[a]));
    endtask

    task automatic wait_clear();
        int n;
        n = 0;
        while (busy && n < 1000) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("clear_cycles", 64'(n), 64'(256));
    endtask

    // Called #1 after an edge with the DUT idle; returns #1 into the idle cycle after done.
    task automatic run_op(input logic o, input logic [31:0] k, input logic [31:0] c);
        int n;
        stub_code = c;
        start = 1'b1; op = o; key = k;
        @(posedge CLK); #1;
        start = 1'b0;
        n = 1;
        chk("crc_start_pulse", 64'(crc_start), 64'(1));
        while (!done && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("done_latency", 64'(n), 64'(LAT));
        model_apply(o, k, c);
        @(posedge CLK); #1;
        chk("busy_after_done", 64'(busy), 64'(0));
        chk("done_one_cycle", 64'(done), 64'(0));
    endtask

    initial begin
        int n, cs0, d0;
        logic [31:0] rk, rc;
        model_clear();

        @(posedge CLK); #1;
        chk("rst_busy",      64'(busy),      64'(1));
        chk("rst_done",      64'(done),      64'(0));
        chk("rst_crc_start", 64'(crc_start), 64'(0));
        chk("rst_crc_key",   64'(crc_key),   64'(0));
        reset = 1'b0;
        wait_clear();
        check_cell(0); check_cell(1); check_cell(255);

        run_op(1'b0, 32'hA5A5A5A5, 32'h00030201);
        check_cell(1); check_cell(2); check_cell(3); check_cell(4);

        run_op(1'b1, 32'hA5A5A5A5, 32'h00030201);
        check_cell(1); check_cell(2); check_cell(3);

        run_op(1'b1, 32'h0BADF00D, 32'h000C0B0A);
        chk("empty_delete_count", 64'(m_cnt[10]), 64'(8'hFF));
        check_cell(10); check_cell(11); check_cell(12);

        run_op(1'b0, 32'h12345678, 32'h00050505);
        check_cell(5); check_cell(4); check_cell(6);

        // A second start while waiting on the CRC must leave no trace.
        cs0 = cs_cnt; d0 = done_cnt;
        stub_code = 32'h00201F1E;
        start = 1'b1; op = 1'b0; key = 32'hCAFEBABE;
        @(posedge CLK); #1;
        start = 1'b0;
        n = 1;
        while (n < 10) begin @(posedge CLK); #1; n++; end
        start = 1'b1; op = 1'b1; key = 32'hDEADBEEF;
        @(posedge CLK); #1;
        start = 1'b0;
        n++;
        chk("busy_key_hold", 64'(crc_key), 64'(32'hCAFEBABE));
        while (!done && n < 100) begin @(posedge CLK); #1; n++; end
        chk("busy_done_latency", 64'(n), 64'(LAT));
        model_apply(1'b0, 32'hCAFEBABE, 32'h00201F1E);
        @(posedge CLK); #1;
        chk("busy_crc_starts", 64'(cs_cnt - cs0), 64'(1));
        chk("busy_done_count", 64'(done_cnt - d0), 64'(1));
        check_cell(30); check_cell(31); check_cell(32);

        // Randomized back-to-back operations, then a full sweep.
        for (int i = 0; i < 6; i++) begin
            rk = $urandom;
            rc = $urandom;
            run_op(1'($urandom_range(0, 1)), rk, rc);
        end
        for (int a = 0; a < 256; a++) check_cell(a);

        // Reset during the second UPD cycle.
        d0 = done_cnt;
        stub_code = 32'h00030201;
        start = 1'b1; op = 1'b0; key = 32'h5EED5EED;
        @(posedge CLK); #1;
        start = 1'b0;
        n = 1;
        while (n < 36) begin @(posedge CLK); #1; n++; end
        reset = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'(1));
        wait_clear();
        chk("abort_no_done", 64'(done_cnt - d0), 64'(0));
        model_clear();
        check_cell(1); check_cell(2); check_cell(5);

        run_op(1'b0, 32'h0F0F0F0F, 32'h00030201);
        check_cell(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
